// File: rtl/sseg_frame_reader.sv
// rtl/sseg_frame_reader.sv - seven-segment bus capture and hex frame reconstruction
module sseg_frame_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     anode,
  input  logic [7:0]            cathode,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_LOCKED
  } state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [DIGITS-1:0]   s_anode;
  logic [7:0]          s_cathode;
  logic [DIGITS-1:0]   p_anode;
  logic [7:0]          p_cathode;
  state_t              state;
  state_t              state_d;
  logic [3:0]          count;
  logic [3:0]          count_d;
  logic                accept;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_d;
  logic [4*DIGITS-1:0] shadow_val;
  logic [4*DIGITS-1:0] shadow_val_d;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_dp_d;
  logic [DIGITS-1:0]   sel;
  logic                multi;
  logic                onehot;
  logic                same;
  logic                nib_ok;
  logic [3:0]          nib;

  // Inverse of the hex segment map; returns {valid, nibble}, nibble 0 when unrecognised.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h3F:   decode_seg = {1'b1, 4'h0};
      7'h06:   decode_seg = {1'b1, 4'h1};
      7'h5B:   decode_seg = {1'b1, 4'h2};
      7'h4F:   decode_seg = {1'b1, 4'h3};
      7'h66:   decode_seg = {1'b1, 4'h4};
      7'h6D:   decode_seg = {1'b1, 4'h5};
      7'h7D:   decode_seg = {1'b1, 4'h6};
      7'h07:   decode_seg = {1'b1, 4'h7};
      7'h7F:   decode_seg = {1'b1, 4'h8};
      7'h6F:   decode_seg = {1'b1, 4'h9};
      7'h77:   decode_seg = {1'b1, 4'hA};
      7'h7C:   decode_seg = {1'b1, 4'hB};
      7'h39:   decode_seg = {1'b1, 4'hC};
      7'h5E:   decode_seg = {1'b1, 4'hD};
      7'h79:   decode_seg = {1'b1, 4'hE};
      7'h71:   decode_seg = {1'b1, 4'hF};
      default: decode_seg = {1'b0, 4'h0};
    endcase
  endfunction

  // Register the bus once and keep the previous sample for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_anode   <= '1;
      s_cathode <= '0;
      p_anode   <= '1;
      p_cathode <= '0;
    end else begin
      s_anode   <= anode;
      s_cathode <= cathode;
      p_anode   <= s_anode;
      p_cathode <= s_cathode;
    end
  end

  // Classify the registered sample: selected digits, collisions, and whether it moved.
  always_comb begin
    sel    = ~s_anode;
    multi  = (sel & (sel - DIGITS'(1))) != '0;
    onehot = (sel != '0) && !multi;
    same   = (s_anode == p_anode) && (s_cathode == p_cathode);
  end

  assign {nib_ok, nib} = decode_seg(s_cathode[6:0]);

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  // Dwell tracking: one acceptance once the sample has repeated STABLE_CYCLES times.
  always_comb begin
    state_d = state;
    count_d = count;
    accept  = 1'b0;
    if (clear || !onehot) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_d = ST_TRACK;
          count_d = 4'd1;
        end
        ST_TRACK: begin
          if (!same) begin
            count_d = 4'd1;
          end else if (count == STABLE) begin
            state_d = ST_LOCKED;
            accept  = 1'b1;
          end else begin
            count_d = count + 4'd1;
          end
        end
        ST_LOCKED: begin
          if (!same) begin
            state_d = ST_TRACK;
            count_d = 4'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // Shadow contents as they would be with the current digit merged in.
  always_comb begin
    shadow_val_d = shadow_val;
    shadow_dp_d  = shadow_dp;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel[i]) begin
        shadow_val_d[4*i +: 4] = nib;
        shadow_dp_d[i]         = s_cathode[7];
      end
    end
    seen_d = seen | sel;
  end

  // Frame assembly, publishing and error flags; clear outranks a same-cycle acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      dp          <= '0;
      frame_valid <= 1'b0;
      digit_err   <= '0;
      bus_err     <= 1'b0;
      seen        <= '0;
      shadow_val  <= '0;
      shadow_dp   <= '0;
    end else begin
      frame_valid <= 1'b0;
      bus_err     <= multi;
      if (clear) begin
        seen      <= '0;
        digit_err <= '0;
      end else if (accept) begin
        shadow_val <= shadow_val_d;
        shadow_dp  <= shadow_dp_d;
        if (!nib_ok) begin
          digit_err <= digit_err | sel;
        end
        if (&seen_d) begin
          value       <= shadow_val_d;
          dp          <= shadow_dp_d;
          frame_valid <= 1'b1;
          seen        <= '0;
        end else begin
          seen <= seen_d;
        end
      end
    end
  end

endmodule
